// File: rtl/conv_post_quant.sv
// conv_post_quant: rescale, saturate and activate the adder-tree sum, then
// buffer results in a small ready/valid FIFO.
// Optional feature: define CONV_POST_HSWISH_EN to build the hard-swish
// multipliers for act_mode 3; otherwise mode 3 behaves as identity.
module conv_post_quant #(
  parameter int bitsize    = 14,
  parameter int FRAC_BITS  = 7,
  parameter int IN_W       = 19,
  parameter int OUT_SHIFT  = 0,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic signed [IN_W-1:0]        sum_in,
  input  logic                          sum_valid,
  input  logic [1:0]                    act_mode,
  output logic signed [bitsize-1:0]     out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow_err
);

  localparam int SW = IN_W + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic signed [bitsize-1:0] SAT_HI = {1'b0, {(bitsize-1){1'b1}}};
  localparam logic signed [bitsize-1:0] SAT_LO = {1'b1, {(bitsize-1){1'b0}}};
  localparam logic signed [bitsize-1:0] SIX    = bitsize'(6 << FRAC_BITS);

  // ---------------- stage A: rescale with round-half-up ----------------
  logic signed [SW-1:0] sum_ext, s_next;
  logic signed [SW-1:0] a_s_reg;
  logic [1:0]           a_mode_reg;
  logic                 a_valid_reg;

  assign sum_ext = {sum_in[IN_W-1], sum_in};

  generate
    if (OUT_SHIFT == 0) begin : g_noshift
      assign s_next = sum_ext;
    end else begin : g_shift
      localparam logic signed [SW-1:0] HALF = SW'(1 << (OUT_SHIFT - 1));
      assign s_next = (sum_ext + HALF) >>> OUT_SHIFT;
    end
  endgenerate

  // Stage A register: rescaled sum with its activation mode
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_valid_reg <= 1'b0;
      a_s_reg     <= '0;
      a_mode_reg  <= '0;
    end else begin
      a_valid_reg <= sum_valid;
      a_s_reg     <= s_next;
      a_mode_reg  <= act_mode;
    end
  end

  // ---------------- stage B: saturate and clamp ----------------
  logic signed [bitsize-1:0] x_sat, b_y_next, b_y_reg;
  logic                      b_valid_reg;

  // Saturate to the activation width, then apply ReLU / ReLU6 clamps
  always_comb begin
    x_sat = a_s_reg[bitsize-1:0];
    if (a_s_reg > SW'(SAT_HI))      x_sat = SAT_HI;
    else if (a_s_reg < SW'(SAT_LO)) x_sat = SAT_LO;
    b_y_next = x_sat;
    if ((a_mode_reg == 2'd1 || a_mode_reg == 2'd2) && x_sat < 0) b_y_next = '0;
    else if (a_mode_reg == 2'd2 && x_sat > SIX)                  b_y_next = SIX;
  end

`ifdef CONV_POST_HSWISH_EN
  logic b_hs_reg;
`endif

  // Stage B register: clamped activation input
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b_valid_reg <= 1'b0;
      b_y_reg     <= '0;
`ifdef CONV_POST_HSWISH_EN
      b_hs_reg    <= 1'b0;
`endif
    end else begin
      b_valid_reg <= a_valid_reg;
      b_y_reg     <= b_y_next;
`ifdef CONV_POST_HSWISH_EN
      b_hs_reg    <= (a_mode_reg == 2'd3);
`endif
    end
  end

  // ---------------- stage C: optional hard-swish ----------------
  logic signed [bitsize-1:0] c_y_next, c_y_reg;
  logic                      c_valid_reg;

`ifdef CONV_POST_HSWISH_EN
  localparam int RW = bitsize + 1;
  localparam int MW = bitsize + RW;
  localparam int QW = MW + 18;
  localparam logic signed [RW-1:0] SIX_R = RW'(6 << FRAC_BITS);
  logic signed [RW-1:0]      xr_sum, r_val;
  logic signed [MW-1:0]      xr_prod, p_val;
  logic signed [QW-1:0]      q_val, y_wide;
  logic signed [bitsize-1:0] hs_y;

  // x * relu6(x+3) / 6, with 1/6 approximated as 21845 / 2^17
  always_comb begin
    xr_sum = RW'(b_y_reg) + RW'(3 << FRAC_BITS);
    r_val  = xr_sum;
    if (xr_sum < 0)          r_val = '0;
    else if (xr_sum > SIX_R) r_val = SIX_R;
    xr_prod = MW'(b_y_reg) * MW'(r_val);
    p_val   = xr_prod >>> FRAC_BITS;
    q_val   = QW'(p_val) * QW'(21845) + QW'(65536);
    y_wide  = q_val >>> 17;
    hs_y    = y_wide[bitsize-1:0];
    if (y_wide > QW'(SAT_HI))      hs_y = SAT_HI;
    else if (y_wide < QW'(SAT_LO)) hs_y = SAT_LO;
    c_y_next = b_hs_reg ? hs_y : b_y_reg;
  end
`else
  assign c_y_next = b_y_reg;
`endif

  // Stage C register: final activation waiting for the FIFO
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_valid_reg <= 1'b0;
      c_y_reg     <= '0;
    end else begin
      c_valid_reg <= b_valid_reg;
      c_y_reg     <= c_y_next;
    end
  end

  // ---------------- output FIFO ----------------
  logic signed [bitsize-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]             wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]             count_reg, count_next;
  logic signed [bitsize-1:0] out_data_reg, head_next;
  logic                      overflow_reg;
  logic                      full, pop, push, drop;

  assign out_valid    = (count_reg != '0);
  assign full         = (count_reg == CW'(FIFO_DEPTH));
  assign pop          = out_valid && out_ready;
  assign push         = c_valid_reg && (!full || pop);
  assign drop         = c_valid_reg && full && !pop;
  assign rd_ptr_next  = pop ? rd_ptr_reg + PW'(1) : rd_ptr_reg;
  assign out_data     = out_data_reg;
  assign fifo_count   = count_reg;
  assign overflow_err = overflow_reg;

  // Next occupancy and next head; a write into an empty-after-pop FIFO
  // is forwarded so the head register never reads a stale slot
  always_comb begin
    count_next = count_reg;
    if (push && !pop)      count_next = count_reg + CW'(1);
    else if (pop && !push) count_next = count_reg - CW'(1);
    head_next = mem[rd_ptr_next];
    if (push && (count_reg == CW'(pop))) head_next = c_y_reg;
  end

  // Storage array write port
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= c_y_reg;
  end

  // Pointers, occupancy, registered head and sticky overflow flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      out_data_reg <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      if (count_next != '0) out_data_reg <= head_next;
      if (drop) overflow_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_conv_post_quant.sv
// Scoreboard bench for conv_post_quant: a default instance (OUT_SHIFT=0)
// and a rescaling instance (OUT_SHIFT=2) sharing sum_in/act_mode.
module tb_conv_post_quant;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic signed [18:0] sum_in = '0;
  logic [1:0]         act_mode = '0;
  logic               sum_valid = 1'b0;
  logic               sum_valid_sh = 1'b0;
  logic               out_ready = 1'b1;
  logic               out_ready_sh = 1'b1;
  logic signed [13:0] out_data, out_data_sh;
  logic               out_valid, out_valid_sh;
  logic [3:0]         fifo_count, fifo_count_sh;
  logic               overflow_err, overflow_err_sh;

  int vec_count = 0;
  int err_count = 0;
  int extra_outs = 0;
  int exp_q[$];
  int exp_q_sh[$];

  always #5 clk = ~clk;

  conv_post_quant #(.OUT_SHIFT(0)) dut (
    .clk(clk), .rst(rst), .sum_in(sum_in), .sum_valid(sum_valid),
    .act_mode(act_mode), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .fifo_count(fifo_count), .overflow_err(overflow_err)
  );

  conv_post_quant #(.OUT_SHIFT(2)) dut_sh (
    .clk(clk), .rst(rst), .sum_in(sum_in), .sum_valid(sum_valid_sh),
    .act_mode(act_mode), .out_data(out_data_sh), .out_valid(out_valid_sh),
    .out_ready(out_ready_sh), .fifo_count(fifo_count_sh),
    .overflow_err(overflow_err_sh)
  );

  task automatic check_value(input string tag, input int got, input int exp);
    vec_count++;
    if (got !== exp) begin
      err_count++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint sat14(input longint v);
    if (v > 8191)  return 8191;
    if (v < -8192) return -8192;
    return v;
  endfunction

  // Reference arithmetic for one sample
  function automatic int model(input int sum, input int mode, input int sh);
    longint s, x, y;
    s = sum;
    if (sh > 0) s = (s + (longint'(1) << (sh - 1))) >>> sh;
    x = sat14(s);
    y = x;
    if (mode == 1 && x < 0) y = 0;
    if (mode == 2) y = (x < 0) ? 0 : ((x > 768) ? 768 : x);
`ifdef CONV_POST_HSWISH_EN
    if (mode == 3) begin
      longint r, p;
      r = x + 384;
      if (r < 0)   r = 0;
      if (r > 768) r = 768;
      p = (x * r) >>> 7;
      y = sat14((p * 21845 + 65536) >>> 17);
    end
`endif
    return int'(y);
  endfunction

  // Drive one sample on the next cycle; optionally record its expected result
  task automatic send(input int v, input int m, input bit to_sh, input int exp, input bit keep);
    @(posedge clk); #1;
    sum_in = 19'(v);
    act_mode = 2'(m);
    sum_valid = !to_sh;
    sum_valid_sh = to_sh;
    if (keep) begin
      if (to_sh) exp_q_sh.push_back(exp);
      else       exp_q.push_back(exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      sum_valid = 1'b0;
      sum_valid_sh = 1'b0;
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0 && exp_q_sh.size() == 0) break;
      @(negedge clk);
    end
    check_value("drain_timeout", exp_q.size() + exp_q_sh.size(), 0);
  endtask

  // Scoreboard for the default instance
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        extra_outs++;
        $display("FAIL spurious_out: got %0d expected no output", out_data);
      end else begin
        check_value("out", out_data, exp_q.pop_front());
      end
    end
  end

  // Scoreboard for the rescaling instance
  always @(negedge clk) begin
    if (rst && out_valid_sh && out_ready_sh) begin
      if (exp_q_sh.size() == 0) begin
        extra_outs++;
        $display("FAIL spurious_out_sh: got %0d expected no output", out_data_sh);
      end else begin
        check_value("out_sh", out_data_sh, exp_q_sh.pop_front());
      end
    end
  end

  initial begin
    int lat;
    int v;
    int m;
    int hs_exp[4];
    int hs_in[4];

    // Reset state
    repeat (2) @(negedge clk);
    check_value("rst_out_valid", out_valid, 0);
    check_value("rst_out_data", out_data, 0);
    check_value("rst_fifo_count", fifo_count, 0);
    check_value("rst_overflow", overflow_err, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Identity and latency
    send(1000, 0, 0, 1000, 1);
    @(posedge clk); #1;
    sum_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    check_value("latency", lat, 4);
    send(20000, 0, 0, 8191, 1);
    send(-20000, 0, 0, -8192, 1);

    // ReLU / ReLU6 with alternating modes back-to-back
    send(-50, 1, 0, 0, 1);
    send(1000, 1, 0, 1000, 1);
    send(1000, 2, 0, 768, 1);
    send(-50, 2, 0, 0, 1);
    send(1000, 1, 0, 1000, 1);
    send(1000, 2, 0, 768, 1);
    send(1000, 0, 0, 1000, 1);

    // Hard-swish (or identity when the multipliers are not built)
    hs_in = '{128, -128, -512, 1000};
`ifdef CONV_POST_HSWISH_EN
    hs_exp = '{85, -43, 0, 1000};
`else
    hs_exp = '{128, -128, -512, 1000};
`endif
    for (int i = 0; i < 4; i++) send(hs_in[i], 3, 0, hs_exp[i], 1);
    idle(1);
    wait_drain();

    // Rescale with OUT_SHIFT=2
    send(6, 0, 1, 2, 1);
    send(5, 0, 1, 1, 1);
    send(-6, 0, 1, -1, 1);
    for (int i = 0; i < 60; i++) begin
      v = int'($urandom_range(524287)) - 262144;
      m = int'($urandom_range(3));
      send(v, m, 1, model(v, m, 2), 1);
    end
    idle(1);
    wait_drain();

    // Backpressure and overflow
    out_ready = 1'b0;
    for (int i = 1; i <= 10; i++) send(i, 0, 0, i, i <= 8);
    idle(6);
    @(negedge clk);
    check_value("full_count", fifo_count, 8);
    check_value("overflow_set", overflow_err, 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain();
    @(negedge clk);
    check_value("drained_count", fifo_count, 0);
    check_value("overflow_sticky", overflow_err, 1);

    // Reset with 3 samples in the pipeline and 4 in the FIFO
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) send(100 + i, 0, 0, 0, 0);
    @(posedge clk); #1;
    sum_valid = 1'b0;
    rst = 1'b0;
    #1;
    check_value("midrst_out_valid", out_valid, 0);
    check_value("midrst_fifo_count", fifo_count, 0);
    check_value("midrst_overflow", overflow_err, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    out_ready = 1'b1;
    repeat (12) @(negedge clk);
    check_value("post_reset_outs", extra_outs, 0);

    // Random mix, consumer always ready
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(3) != 0) begin
        v = int'($urandom_range(40000)) - 20000;
        m = int'($urandom_range(3));
        send(v, m, 0, model(v, m, 0), 1);
      end else begin
        idle(1);
      end
    end
    idle(1);
    wait_drain();
    repeat (6) @(negedge clk);
    check_value("final_count", fifo_count, 0);
    check_value("sh_overflow", overflow_err_sh, 0);
    check_value("sh_count", fifo_count_sh, 0);
    check_value("spurious_outputs", extra_outs, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

  // Hard stop if the sequence above ever stalls
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
